// File: rtl/sram_rw_sequencer_pkg.sv
// Shared types and defaults for the SRAM read/write sequencer.
// Holds the FSM state enum, the default phase lengths and the phase-counter type.
package sram_rw_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_DRIVE,
    W_REC,
    R_PCH,
    R_WL,
    R_SENSE,
    R_DONE
  } sram_seq_state_t;

  localparam int DEF_PCH_CYCLES  = 2;
  localparam int DEF_WL_CYCLES   = 2;
  localparam int DEF_SAEN_CYCLES = 1;
  localparam int DEF_WR_CYCLES   = 2;

  localparam int PHASE_CNT_W = 8;
  typedef logic [PHASE_CNT_W-1:0] phase_cnt_t;

  // The counter counts down to zero, so a phase of N cycles loads N-1.
  function automatic phase_cnt_t phase_load(input int cycles);
    return phase_cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/sram_rw_sequencer_onehot_decoder.sv
// Row address to one-hot wordline decoder.
// Addresses outside the row range decode to all zeros and clear in_range.
module onehot_decoder #(
  parameter int N  = 128,
  parameter int AW = $clog2(N)
) (
  input  logic [AW-1:0] addr,
  output logic [N-1:0]  onehot,
  output logic          in_range
);

  always_comb begin
    onehot   = '0;
    in_range = (int'(addr) < N);
    for (int r = 0; r < N; r++) begin
      onehot[r] = (int'(addr) == r);
    end
  end

endmodule

// File: rtl/sram_rw_sequencer.sv
// Responder end of the SRAM request/response protocol.
// Sequences the analog macro's precharge, wordline, write and sense-amp pins.
module sram_rw_sequencer
  import sram_rw_sequencer_pkg::*;
#(
  parameter int numRows     = 128,
  parameter int numCols     = 32,
  parameter int PCH_CYCLES  = DEF_PCH_CYCLES,
  parameter int WL_CYCLES   = DEF_WL_CYCLES,
  parameter int SAEN_CYCLES = DEF_SAEN_CYCLES,
  parameter int WR_CYCLES   = DEF_WR_CYCLES
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       mac_en_i,
  input  logic                       rq_valid_i,
  input  logic                       rq_wr_i,
  input  logic [$clog2(numRows)-1:0] addr_i,
  input  logic [numCols-1:0]         wr_data_i,
  output logic                       rq_ready_o,
  output logic                       rd_valid_o,
  output logic [numCols-1:0]         rd_data_o,
  output logic [numRows-1:0]         wl_o,
  output logic                       pch_o,
  output logic [numCols-1:0]         wr_data_o,
  output logic                       write_o,
  output logic [numCols-1:0]         csel_o,
  output logic                       saen_o,
  input  logic [numCols-1:0]         sa_out_i
);

  localparam int AW = $clog2(numRows);

  localparam phase_cnt_t PCH_LOAD  = phase_load(PCH_CYCLES);
  localparam phase_cnt_t WL_LOAD   = phase_load(WL_CYCLES);
  localparam phase_cnt_t SAEN_LOAD = phase_load(SAEN_CYCLES);
  localparam phase_cnt_t WR_LOAD   = phase_load(WR_CYCLES);

  sram_seq_state_t      state;
  phase_cnt_t           phase_cnt;
  logic [AW-1:0]        addr_q;
  logic                 addr_ok_q;
  logic [AW-1:0]        dec_addr;
  logic [numRows-1:0]   dec_row;
  logic                 dec_in_range;

  // In IDLE the live address is decoded so a write can raise its wordline on the accept edge.
  assign dec_addr = (state == IDLE) ? addr_i : addr_q;

  onehot_decoder #(
    .N  (numRows),
    .AW (AW)
  ) u_row_dec (
    .addr     (dec_addr),
    .onehot   (dec_row),
    .in_range (dec_in_range)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      phase_cnt  <= '0;
      addr_q     <= '0;
      addr_ok_q  <= 1'b0;
      rq_ready_o <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      wl_o       <= '0;
      pch_o      <= 1'b0;
      wr_data_o  <= '0;
      write_o    <= 1'b0;
      csel_o     <= '0;
      saen_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rq_ready_o <= !mac_en_i;
          rd_valid_o <= 1'b0;
          wl_o       <= '0;
          pch_o      <= 1'b0;
          wr_data_o  <= '0;
          write_o    <= 1'b0;
          csel_o     <= '0;
          saen_o     <= 1'b0;
          if (rq_valid_i && rq_ready_o) begin
            addr_q     <= addr_i;
            addr_ok_q  <= dec_in_range;
            rq_ready_o <= 1'b0;
            if (rq_wr_i) begin
              state     <= W_DRIVE;
              phase_cnt <= WR_LOAD;
              write_o   <= 1'b1;
              csel_o    <= '1;
              wr_data_o <= wr_data_i;
              wl_o      <= dec_row;
            end else begin
              state     <= R_PCH;
              phase_cnt <= PCH_LOAD;
              pch_o     <= 1'b1;
            end
          end
        end

        W_DRIVE: begin
          if (phase_cnt == '0) begin
            state   <= W_REC;
            wl_o    <= '0;
            write_o <= 1'b0;
            csel_o  <= '0;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end

        W_REC: begin
          state      <= IDLE;
          wr_data_o  <= '0;
          rq_ready_o <= !mac_en_i;
        end

        R_PCH: begin
          if (phase_cnt == '0) begin
            state     <= R_WL;
            phase_cnt <= WL_LOAD;
            pch_o     <= 1'b0;
            wl_o      <= dec_row;
            csel_o    <= '1;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end

        R_WL: begin
          if (phase_cnt == '0) begin
            state     <= R_SENSE;
            phase_cnt <= SAEN_LOAD;
            saen_o    <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end

        // Out-of-range reads never raised a wordline, so they return zero rather than floating bitlines.
        R_SENSE: begin
          if (phase_cnt == '0) begin
            state      <= R_DONE;
            rd_data_o  <= addr_ok_q ? sa_out_i : '0;
            rd_valid_o <= 1'b1;
            saen_o     <= 1'b0;
            wl_o       <= '0;
            csel_o     <= '0;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end

        R_DONE: begin
          state      <= IDLE;
          rd_valid_o <= 1'b0;
          rq_ready_o <= !mac_en_i;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_rw_sequencer.sv
// Self-checking bench for sram_rw_sequencer: directed vector table plus
// hand-written sequences for MAC blocking, mid-operation reset and back-to-back traffic.
module tb_sram_rw_sequencer;

  logic         clk = 1'b0;
  logic         nrst;
  logic         mac_en;
  logic         rq_valid;
  logic         rq_wr;
  logic [6:0]   addr;
  logic [31:0]  wdata;
  logic         rq_ready;
  logic         rd_valid;
  logic [31:0]  rd_data;
  logic [127:0] wl;
  logic         pch;
  logic [31:0]  wr_data_bl;
  logic         write_en;
  logic [31:0]  csel;
  logic         saen;
  logic [31:0]  sa_out;

  logic [31:0]  sa_manual;
  logic         use_model;
  logic [31:0]  model_sa;
  logic [31:0]  mem [128];
  logic         mem_loaded = 1'b0;
  logic         monitor_on;
  logic [31:0]  rd_q [$];

  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    logic         valid;
    logic         wr;
    logic [6:0]   addr;
    logic [31:0]  wdata;
    logic [31:0]  sa;
    logic         e_ready;
    logic         e_rd_valid;
    logic         e_pch;
    logic         e_write;
    logic         e_saen;
    logic [127:0] e_wl;
    logic [31:0]  e_csel;
    logic [31:0]  e_wr_data;
    logic [31:0]  e_rd_data;
  } vec_t;

  vec_t vecs [16];

  sram_rw_sequencer dut (
    .clk        (clk),
    .nrst       (nrst),
    .mac_en_i   (mac_en),
    .rq_valid_i (rq_valid),
    .rq_wr_i    (rq_wr),
    .addr_i     (addr),
    .wr_data_i  (wdata),
    .rq_ready_o (rq_ready),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .wl_o       (wl),
    .pch_o      (pch),
    .wr_data_o  (wr_data_bl),
    .write_o    (write_en),
    .csel_o     (csel),
    .saen_o     (saen),
    .sa_out_i   (sa_out)
  );

  always #5 clk = ~clk;

  // Behavioural macro: writes land on the selected row, sense amps show the selected row.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int r = 0; r < 128; r++) mem[r] <= 32'hC0DE_0000 + 32'(r);
      mem_loaded <= 1'b1;
    end else if (write_en) begin
      for (int r = 0; r < 128; r++) if (wl[r]) mem[r] <= wr_data_bl;
    end
  end

  always_comb begin
    model_sa = '0;
    for (int r = 0; r < 128; r++) if (wl[r]) model_sa = model_sa | mem[r];
  end

  assign sa_out = use_model ? model_sa : sa_manual;

  always @(negedge clk) begin
    if (monitor_on && rd_valid) rd_q.push_back(rd_data);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock; outputs are sampled 1 time unit after the edge, and safety invariants are checked.
  task automatic tick();
    @(posedge clk);
    #1;
    checkOutput("invariants",
                128'(!(pch && |wl) && !(write_en && saen) && $onehot0(wl)), 128'(1'b1));
  endtask

  task automatic applyStimulus(input vec_t v);
    rq_valid  = v.valid;
    rq_wr     = v.wr;
    addr      = v.addr;
    wdata     = v.wdata;
    sa_manual = v.sa;
  endtask

  initial begin
    int waited;
    int n;
    logic saw_ready;
    logic accepted;

    nrst = 1'b0; mac_en = 1'b0; rq_valid = 1'b0; rq_wr = 1'b0;
    addr = '0; wdata = '0; sa_manual = '0; use_model = 1'b0; monitor_on = 1'b0;

    //          valid wr addr  wdata         sa            rdy rv pch wr sa wl        csel          wr_data       rd_data
    vecs[0]  = '{1'b0,1'b0,7'd0,32'h0,        32'h0,        1'b1,1'b0,1'b0,1'b0,1'b0,128'h0,  32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1'b1,1'b1,7'd5,32'hDEADBEEF, 32'h0,        1'b0,1'b0,1'b0,1'b1,1'b0,128'h20, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b0,1'b0,7'd9,32'h0,        32'h0,        1'b0,1'b0,1'b0,1'b1,1'b0,128'h20, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h0};
    vecs[3]  = '{1'b0,1'b0,7'd9,32'h0,        32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,128'h0,  32'h0,        32'hDEADBEEF, 32'h0};
    vecs[4]  = '{1'b0,1'b0,7'd9,32'h0,        32'h0,        1'b1,1'b0,1'b0,1'b0,1'b0,128'h0,  32'h0,        32'h0,        32'h0};
    vecs[5]  = '{1'b1,1'b0,7'd5,32'h0,        32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,128'h0,  32'h0,        32'h0,        32'h0};
    vecs[6]  = '{1'b0,1'b0,7'd9,32'h0,        32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,128'h0,  32'h0,        32'h0,        32'h0};
    vecs[7]  = '{1'b0,1'b0,7'd9,32'h0,        32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,128'h20, 32'hFFFFFFFF, 32'h0,        32'h0};
    vecs[8]  = '{1'b0,1'b0,7'd9,32'h0,        32'h12345678, 1'b0,1'b0,1'b0,1'b0,1'b0,128'h20, 32'hFFFFFFFF, 32'h0,        32'h0};
    vecs[9]  = '{1'b0,1'b0,7'd9,32'h0,        32'h12345678, 1'b0,1'b0,1'b0,1'b0,1'b1,128'h20, 32'hFFFFFFFF, 32'h0,        32'h0};
    vecs[10] = '{1'b0,1'b0,7'd9,32'h0,        32'hDEADBEEF, 1'b0,1'b1,1'b0,1'b0,1'b0,128'h0,  32'h0,        32'h0,        32'hDEADBEEF};
    vecs[11] = '{1'b0,1'b0,7'd9,32'h0,        32'h0,        1'b1,1'b0,1'b0,1'b0,1'b0,128'h0,  32'h0,        32'h0,        32'hDEADBEEF};
    vecs[12] = '{1'b1,1'b1,7'd7,32'h0F0F0F0F, 32'h0,        1'b0,1'b0,1'b0,1'b1,1'b0,128'h80, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'hDEADBEEF};
    vecs[13] = '{1'b0,1'b0,7'd9,32'h0,        32'h0,        1'b0,1'b0,1'b0,1'b1,1'b0,128'h80, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'hDEADBEEF};
    vecs[14] = '{1'b0,1'b0,7'd9,32'h0,        32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,128'h0,  32'h0,        32'h0F0F0F0F, 32'hDEADBEEF};
    vecs[15] = '{1'b0,1'b0,7'd9,32'h0,        32'h0,        1'b1,1'b0,1'b0,1'b0,1'b0,128'h0,  32'h0,        32'h0,        32'hDEADBEEF};

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_ready",    128'(rq_ready),   128'(1'b0));
    checkOutput("rst_rd_valid", 128'(rd_valid),   128'(1'b0));
    checkOutput("rst_rd_data",  128'(rd_data),    128'h0);
    checkOutput("rst_wl",       wl,               128'h0);
    checkOutput("rst_pch",      128'(pch),        128'(1'b0));
    checkOutput("rst_write",    128'(write_en),   128'(1'b0));
    checkOutput("rst_csel",     128'(csel),       128'h0);
    checkOutput("rst_saen",     128'(saen),       128'(1'b0));
    checkOutput("rst_wr_data",  128'(wr_data_bl), 128'h0);
    nrst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("v%0d_ready", i),    128'(rq_ready),   128'(vecs[i].e_ready));
      checkOutput($sformatf("v%0d_rd_valid", i), 128'(rd_valid),   128'(vecs[i].e_rd_valid));
      checkOutput($sformatf("v%0d_pch", i),      128'(pch),        128'(vecs[i].e_pch));
      checkOutput($sformatf("v%0d_write", i),    128'(write_en),   128'(vecs[i].e_write));
      checkOutput($sformatf("v%0d_saen", i),     128'(saen),       128'(vecs[i].e_saen));
      checkOutput($sformatf("v%0d_wl", i),       wl,               vecs[i].e_wl);
      checkOutput($sformatf("v%0d_csel", i),     128'(csel),       128'(vecs[i].e_csel));
      checkOutput($sformatf("v%0d_wr_data", i),  128'(wr_data_bl), 128'(vecs[i].e_wr_data));
      checkOutput($sformatf("v%0d_rd_data", i),  128'(rd_data),    128'(vecs[i].e_rd_data));
    end

    // MAC mode raised during R_WL: read finishes, held request waits for mac_en to drop.
    use_model = 1'b1;
    rq_valid = 1'b1; rq_wr = 1'b0; addr = 7'd5;
    tick();
    rq_valid = 1'b0;
    tick(); tick();
    checkOutput("mac_rwl_wl", wl, 128'h20);
    mac_en = 1'b1;
    tick(); tick(); tick();
    checkOutput("mac_rd_valid", 128'(rd_valid), 128'(1'b1));
    checkOutput("mac_rd_data",  128'(rd_data),  128'hDEADBEEF);
    rq_valid = 1'b1; rq_wr = 1'b1; addr = 7'd9; wdata = 32'h0000_0055;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("mac_ready_low%0d", i), 128'(rq_ready), 128'(1'b0));
      checkOutput($sformatf("mac_no_accept%0d", i), 128'(write_en), 128'(1'b0));
    end
    mac_en = 1'b0;
    tick();
    checkOutput("mac_ready_back", 128'(rq_ready), 128'(1'b1));
    checkOutput("mac_not_yet",    128'(write_en), 128'(1'b0));
    tick();
    checkOutput("mac_held_write", 128'(write_en),   128'(1'b1));
    checkOutput("mac_held_wl",    wl,               128'h200);
    checkOutput("mac_held_data",  128'(wr_data_bl), 128'h55);
    rq_valid = 1'b0;
    tick(); tick(); tick();
    checkOutput("mac_idle_ready", 128'(rq_ready), 128'(1'b1));

    // Reset during W_DRIVE aborts at once; a later read of an untouched row still works.
    rq_valid = 1'b1; rq_wr = 1'b1; addr = 7'd20; wdata = 32'hA5A5A5A5;
    tick();
    rq_valid = 1'b0;
    checkOutput("abort_pre_write", 128'(write_en), 128'(1'b1));
    #2 nrst = 1'b0;
    #1;
    checkOutput("abort_write", 128'(write_en), 128'(1'b0));
    checkOutput("abort_wl",    wl,             128'h0);
    checkOutput("abort_ready", 128'(rq_ready), 128'(1'b0));
    tick();
    checkOutput("abort_no_rd_valid", 128'(rd_valid), 128'(1'b0));
    #2 nrst = 1'b1;
    tick();
    checkOutput("abort_idle_ready", 128'(rq_ready), 128'(1'b1));
    rq_valid = 1'b1; rq_wr = 1'b0; addr = 7'd100;
    tick();
    rq_valid = 1'b0;
    n = 1;
    while (!rd_valid && n < 12) begin
      tick();
      n++;
    end
    checkOutput("abort_read_latency", 128'(n),        128'd6);
    checkOutput("abort_read_valid",   128'(rd_valid), 128'(1'b1));
    checkOutput("abort_read_data",    128'(rd_data),  128'hC0DE0064);
    tick();
    checkOutput("abort_read_pulse",   128'(rd_valid), 128'(1'b0));
    checkOutput("abort_read_ready",   128'(rq_ready), 128'(1'b1));

    // Back-to-back: 128 writes then 128 reads with rq_valid held high.
    monitor_on = 1'b1;
    for (int k = 0; k < 256; k++) begin
      rq_valid = 1'b1;
      rq_wr    = (k < 128);
      addr     = 7'(k % 128);
      wdata    = 32'(k % 128) * 32'h01010101;
      waited   = 0;
      accepted = 1'b0;
      while (!accepted && waited < 20) begin
        saw_ready = rq_ready;
        tick();
        waited++;
        if (saw_ready) accepted = 1'b1;
      end
      if (!accepted) checkOutput($sformatf("b2b_accept%0d", k), 128'(accepted), 128'(1'b1));
      else if (k != 0 && k != 128)
        checkOutput($sformatf("b2b_gap%0d", k), 128'(waited), (k < 128) ? 128'd4 : 128'd7);
    end
    rq_valid = 1'b0;
    repeat (10) tick();
    checkOutput("b2b_read_count", 128'(rd_q.size()), 128'd128);
    for (int j = 0; j < 128 && j < rd_q.size(); j++)
      checkOutput($sformatf("b2b_read%0d", j), 128'(rd_q[j]), 128'(32'(j) * 32'h01010101));

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/sram_rw_sequencer.md
Name: sram_rw_sequencer

Overview:
- Responder end of the `sram_itf` request/response protocol.
- Accepts single-word read/write requests and drives the analog macro's write/read control pins: WL, PCH, WR_DATA, WRITE, CSEL, SAEN.
- Captures the sense-amp outputs and returns read data with a one-cycle valid pulse.
- Sits inside the accelerator wrapper, between the SRAM interface slave modport and the `to_analog`/`from_analog` bundles. It blocks SRAM access while MAC mode is enabled.

Parameters:
- numRows, 128, SRAM rows (wordlines).
- numCols, 32, SRAM columns (word width).
- PCH_CYCLES, 2, precharge phase length in clocks (≥1).
- WL_CYCLES, 2, read wordline phase length (≥1).
- SAEN_CYCLES, 1, sense-enable phase length (≥1).
- WR_CYCLES, 2, write wordline phase length (≥1).

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- mac_en_i  in  1  MAC mode active; inhibits new SRAM requests
- rq_valid_i  in  1  request valid
- rq_wr_i  in  1  1 = write, 0 = read
- addr_i  in  $clog2(numRows)  row address
- wr_data_i  in  numCols  write word
- rq_ready_o  out  1  request may be accepted
- rd_valid_o  out  1  read data valid, one-cycle pulse
- rd_data_o  out  numCols  read word
- wl_o  out  numRows  one-hot wordline
- pch_o  out  1  bitline precharge, active high
- wr_data_o  out  numCols  write data to bitline drivers
- write_o  out  1  write driver enable
- csel_o  out  numCols  column select
- saen_o  out  1  sense-amp enable
- sa_out_i  in  numCols  sense-amp outputs from macro

Behaviour:
- All outputs registered.
- Reset value of every output is 0, and the FSM resets to IDLE. Reset asserted mid-operation aborts immediately: WL/WRITE/SAEN drop asynchronously and no rd_valid is issued.
- rq_ready_o = (state == IDLE) && !mac_en_i, registered so it is valid in the same cycle as the state.
- Accept occurs on an edge where rq_valid_i && rq_ready_o. On accept, addr_i, rq_wr_i and wr_data_i are latched; the initiator may change them afterwards.
- rq_valid_i while not ready is ignored, with no queuing. The request is held by the initiator.

State machine (a phase counter reloads on every state entry):
- IDLE: all controls 0. Accept → W_DRIVE or R_PCH.
- W_DRIVE, WR_CYCLES cycles: write_o=1, csel_o=all-ones, wr_data_o=latched data, wl_o=onehot(addr). Then → W_REC.
- W_REC, 1 cycle: wl_o=0, write_o=0, csel_o=0; wr_data_o holds. Then → IDLE.
- R_PCH, PCH_CYCLES cycles: pch_o=1. Then → R_WL.
- R_WL, WL_CYCLES cycles: pch_o=0, wl_o=onehot(addr), csel_o=all-ones. Then → R_SENSE.
- R_SENSE, SAEN_CYCLES cycles: wl_o stays asserted, saen_o=1. sa_out_i is sampled into rd_data_o on the final R_SENSE edge. Then → R_DONE.
- R_DONE, 1 cycle: rd_valid_o=1, all controls 0. Then → IDLE.

Latencies (cycle 1 = first cycle after the accept edge):
- Read: rd_valid_o high in cycle PCH+WL+SAEN+1, which is cycle 6 with defaults.
- Write: the WL pulse spans cycles 1..WR_CYCLES.
- rq_ready_o returns the cycle after R_DONE/W_REC, provided mac_en_i is low.

Other rules:
- rd_data_o holds its value until the next read capture. Writes do not alter it.
- mac_en_i rising mid-operation: the current operation completes normally; rq_ready_o stays low while mac_en_i is high.
- wl_o is never multi-hot. Address ≥ numRows gives wl_o=0 for the whole operation; a write becomes a no-op, and a read returns rd_data_o=0 with rd_valid still pulsed.
- pch_o and wl_o are never high in the same cycle. write_o and saen_o are never high simultaneously.

Decomposition:
- qracc_pkg gains the `sram_seq_state_t` enum (IDLE, W_DRIVE, W_REC, R_PCH, R_WL, R_SENSE, R_DONE) and default phase-length constants.
- Sub-module `onehot_decoder` (address → numRows one-hot with out-of-range zeroing), reusable for the MAC row drivers.
- The wrapper maps the flat ports onto the `to_analog_t`/`from_analog_t` fields.

Test Plan:
- Reset, then idle with rq_valid_i=0 → all outputs 0, rq_ready_o=1 one cycle after nrst rises.
- Write addr=5, data=0xDEADBEEF → wl_o=1<<5 with write_o=1 and wr_data_o=0xDEADBEEF for exactly 2 cycles, 1 recovery cycle, rq_ready_o high on cycle 4.
- Read addr=5 with sa_out_i=0xDEADBEEF driven during R_SENSE → pch_o cycles 1–2, wl_o cycles 3–5, saen_o cycle 5, rd_valid_o only in cycle 6, rd_data_o=0xDEADBEEF held after.
- Back-to-back: rq_valid_i held high for 128 writes then 128 reads of a pattern (row i = i*0x01010101) → every read matches, no lost or duplicated handshakes, ready gaps exactly per latency.
- Raise mac_en_i during R_WL of a read → read completes with rd_valid_o; rq_ready_o stays 0 until mac_en_i falls, and a held request is accepted on the next cycle.
- Assert nrst during W_DRIVE → wl_o/write_o drop immediately, no rd_valid_o; after release the FSM is in IDLE, and a subsequent read of an unwritten row completes normally.
